// File: rtl/seg_ctrl_pkg.sv
// seg_ctrl_pkg: shared types, widths and helpers for the seg display scheduler.
package seg_ctrl_pkg;
    localparam int DATA_W      = 32;
    localparam int NUM_SRC_DEF = 4;
    typedef enum logic [1:0] {SCAN, SHOW, MANUAL} state_e;
    function automatic logic [31:0] onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction
endpackage

// File: rtl/seg_rr_pick.sv
// seg_rr_pick: combinational round-robin finder, first valid index at or after start.
module seg_rr_pick
    import seg_ctrl_pkg::*;
#(
    parameter int N = NUM_SRC_DEF,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);
    // Walk offsets high to low so the nearest hit from start wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid[start + W'(k)]) begin
                found = 1'b1;
                idx   = start + W'(k);
            end
        end
    end
endmodule

// File: rtl/seg_disp_sched.sv
// seg_disp_sched: round-robin/manual scheduler for the 32-bit seven-segment display word.
// Define SEG_TAG_EN to replace data32[31:28] with the selected source index.
module seg_disp_sched
    import seg_ctrl_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int DWELL   = 50_000_000,
    localparam int SRC_W  = $clog2(NUM_SRC),
    localparam int CNT_W  = $clog2(DWELL)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      step,
    input  logic                      manual_en,
    input  logic [SRC_W-1:0]          manual_sel,
    output logic [DATA_W-1:0]         data32,
    output logic [SRC_W-1:0]          cur_src,
    output logic [NUM_SRC-1:0]        grant,
    output logic                      dwell_tick
);
    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [SRC_W-1:0]    cur_src_q, cur_src_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic                tick_q, tick_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                first_q, first_d;
    logic                found;
    logic [SRC_W-1:0]    pick_idx;
    logic [SRC_W-1:0]    start;

    function automatic logic [DATA_W-1:0] word_of(input logic [NUM_SRC*DATA_W-1:0] d,
                                                  input logic [SRC_W-1:0] i);
        logic [DATA_W-1:0] w;
        w = d[DATA_W*i +: DATA_W];
`ifdef SEG_TAG_EN
        return {4'(i), w[27:0]};
`else
        return w;
`endif
    endfunction

    assign start = first_q ? '0 : cur_src_q + 1'b1;

    seg_rr_pick #(.N(NUM_SRC)) u_pick (
        .valid (src_valid),
        .start (start),
        .found (found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cur_src_d = cur_src_q;
        grant_d   = '0;
        tick_d    = 1'b0;
        cnt_d     = cnt_q;
        first_d   = first_q;
        if (manual_en) begin
            state_d   = MANUAL;
            data_d    = word_of(src_data, manual_sel);
            cur_src_d = manual_sel;
            cnt_d     = '0;
            first_d   = 1'b0;
        end else begin
            case (state_q)
                MANUAL: state_d = SCAN;
                SCAN: begin
                    if (found) begin
                        state_d   = SHOW;
                        data_d    = word_of(src_data, pick_idx);
                        cur_src_d = pick_idx;
                        grant_d   = NUM_SRC'(onehot(32'(pick_idx)));
                        cnt_d     = '0;
                        first_d   = 1'b0;
                    end
                end
                SHOW: begin
                    if (cnt_q == CNT_W'(DWELL - 1) || step) begin
                        state_d = SCAN;
                        tick_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= SCAN;
            data_q    <= '0;
            cur_src_q <= '0;
            grant_q   <= '0;
            tick_q    <= 1'b0;
            cnt_q     <= '0;
            first_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            cur_src_q <= cur_src_d;
            grant_q   <= grant_d;
            tick_q    <= tick_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
        end
    end

    assign data32     = data_q;
    assign cur_src    = cur_src_q;
    assign grant      = grant_q;
    assign dwell_tick = tick_q;
endmodule

// File: tb/tb_seg_disp_sched.sv
// tb_seg_disp_sched: directed vector table plus randomized run against a reference model.
module tb_seg_disp_sched;
    localparam int N  = 4;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  src_valid = '0;
    logic [31:0]   s [N];
    logic [N*32-1:0] src_data;
    logic          step = 1'b0;
    logic          manual_en = 1'b0;
    logic [1:0]    manual_sel = '0;
    logic [31:0]   data32;
    logic [1:0]    cur_src;
    logic [N-1:0]  grant;
    logic          dwell_tick;

    int n_tests = 0;
    int n_fail  = 0;

    assign src_data = {s[3], s[2], s[1], s[0]};

    seg_disp_sched #(.NUM_SRC(N), .DWELL(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .step       (step),
        .manual_en  (manual_en),
        .manual_sel (manual_sel),
        .data32     (data32),
        .cur_src    (cur_src),
        .grant      (grant),
        .dwell_tick (dwell_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ew(int idx, logic [31:0] raw);
`ifdef SEG_TAG_EN
        return {4'(idx), raw[27:0]};
`else
        return raw;
`endif
    endfunction

    // Reference model: mode 0 = searching, 1 = showing, 2 = manual.
    int          m_mode  = 0;
    int          m_left  = 0;
    bit          m_fresh = 1;
    logic [31:0] m_data  = '0;
    int          m_src   = 0;
    logic [3:0]  m_grant = '0;
    logic        m_tick  = 1'b0;

    task automatic model_step();
        m_grant = '0;
        m_tick  = 1'b0;
        if (rst) begin
            m_data = '0; m_src = 0; m_mode = 0; m_fresh = 1;
        end else if (manual_en) begin
            m_mode = 2; m_src = int'(manual_sel); m_data = ew(m_src, s[m_src]); m_fresh = 0;
        end else if (m_mode == 2) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            for (int off = 0; off < N; off++) begin
                int i;
                i = m_fresh ? off : (m_src + 1 + off) % N;
                if (src_valid[i]) begin
                    m_src = i; m_data = ew(i, s[i]); m_grant = 4'(1 << i);
                    m_left = DW; m_mode = 1; m_fresh = 0;
                    break;
                end
            end
        end else begin
            m_left--;
            if (m_left == 0 || step) begin
                m_tick = 1'b1; m_mode = 0;
            end
        end
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(logic r, logic [3:0] v, logic st, logic me, logic [1:0] ms);
        rst = r; src_valid = v; step = st; manual_en = me; manual_sel = ms;
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        logic        r;
        logic [3:0]  v;
        logic        st;
        logic        me;
        logic [1:0]  ms;
        logic [31:0] s2;
        logic [31:0] s3;
        logic [3:0]  eg;
        int          es;
        logic        et;
        logic [31:0] ed;
    } vec_t;

    vec_t vq[$];

    task automatic add(logic r, logic [3:0] v, logic st, logic me, logic [1:0] ms,
                       logic [31:0] s2, logic [31:0] s3,
                       logic [3:0] eg, int es, logic et, logic [31:0] ed);
        vq.push_back('{r, v, st, me, ms, s2, s3, eg, es, et, ed});
    endtask

    initial begin
        logic [31:0] w0, w2, wn, a3, b3, nw;
        s[0] = 32'h1111_1111; s[1] = 32'h5555_AAAA; s[2] = 32'h2222_2222; s[3] = 32'h0;
        w0 = ew(0, 32'h1111_1111); w2 = ew(2, 32'h2222_2222);
        nw = 32'h1234_5678; wn = ew(2, nw);
        a3 = ew(3, 32'hA); b3 = ew(3, 32'hB);
        add(1, 4'b0101, 0, 0, 0, 32'h2222_2222, 32'hA, 4'b0000, 0, 0, 32'h0);
        add(1, 4'b0101, 0, 0, 0, 32'h2222_2222, 32'hA, 4'b0000, 0, 0, 32'h0);
        add(0, 4'b0101, 0, 0, 0, 32'h2222_2222, 32'hA, 4'b0001, 0, 0, w0);
        for (int i = 0; i < 3; i++) add(0, 4'b0101, 0, 0, 0, 32'h2222_2222, 32'hA, 4'b0000, 0, 0, w0);
        add(0, 4'b0101, 0, 0, 0, 32'h2222_2222, 32'hA, 4'b0000, 0, 1, w0);
        add(0, 4'b0101, 0, 0, 0, 32'h2222_2222, 32'hA, 4'b0100, 2, 0, w2);
        for (int i = 0; i < 3; i++) add(0, 4'b0101, 0, 0, 0, 32'h2222_2222, 32'hA, 4'b0000, 2, 0, w2);
        add(0, 4'b0101, 0, 0, 0, 32'h2222_2222, 32'hA, 4'b0000, 2, 1, w2);
        add(0, 4'b0101, 0, 0, 0, 32'h2222_2222, 32'hA, 4'b0001, 0, 0, w0);
        add(0, 4'b0101, 0, 0, 0, 32'h2222_2222, 32'hA, 4'b0000, 0, 0, w0);
        add(0, 4'b0101, 1, 0, 0, 32'h2222_2222, 32'hA, 4'b0000, 0, 1, w0);
        add(0, 4'b0101, 0, 0, 0, 32'h2222_2222, 32'hA, 4'b0100, 2, 0, w2);
        add(0, 4'b0101, 0, 1, 3, 32'h2222_2222, 32'hA, 4'b0000, 3, 0, a3);
        add(0, 4'b0101, 0, 1, 3, 32'h2222_2222, 32'hB, 4'b0000, 3, 0, b3);
        add(0, 4'b0101, 0, 0, 3, 32'h2222_2222, 32'hB, 4'b0000, 3, 0, b3);
        add(0, 4'b0101, 0, 0, 0, 32'h2222_2222, 32'hB, 4'b0001, 0, 0, w0);
        for (int i = 0; i < 3; i++) add(0, 4'b0101, 0, 0, 0, 32'h2222_2222, 32'hB, 4'b0000, 0, 0, w0);
        add(0, 4'b0000, 0, 0, 0, 32'h2222_2222, 32'hB, 4'b0000, 0, 1, w0);
        add(0, 4'b0000, 0, 0, 0, 32'h2222_2222, 32'hB, 4'b0000, 0, 0, w0);
        add(0, 4'b0000, 0, 0, 0, 32'h2222_2222, 32'hB, 4'b0000, 0, 0, w0);
        add(0, 4'b0100, 0, 0, 0, 32'h2222_2222, 32'hB, 4'b0100, 2, 0, w2);
        add(0, 4'b0100, 0, 0, 0, nw, 32'hB, 4'b0000, 2, 0, w2);
        add(0, 4'b0100, 0, 0, 0, nw, 32'hB, 4'b0000, 2, 0, w2);
        add(0, 4'b0100, 0, 0, 0, nw, 32'hB, 4'b0000, 2, 0, w2);
        add(0, 4'b0100, 0, 0, 0, nw, 32'hB, 4'b0000, 2, 1, w2);
        add(0, 4'b0100, 0, 0, 0, nw, 32'hB, 4'b0100, 2, 0, wn);
        add(0, 4'b0100, 0, 0, 0, nw, 32'hB, 4'b0000, 2, 0, wn);
        add(1, 4'b0100, 0, 0, 0, nw, 32'hB, 4'b0000, 0, 0, 32'h0);
        add(1, 4'b0100, 0, 0, 0, nw, 32'hB, 4'b0000, 0, 0, 32'h0);
        add(0, 4'b0100, 0, 0, 0, nw, 32'hB, 4'b0100, 2, 0, wn);

        foreach (vq[k]) begin
            s[2] = vq[k].s2; s[3] = vq[k].s3;
            cyc(vq[k].r, vq[k].v, vq[k].st, vq[k].me, vq[k].ms);
            chk($sformatf("vec%0d data32", k), data32, vq[k].ed);
            chk($sformatf("vec%0d cur_src", k), 32'(cur_src), 32'(vq[k].es));
            chk($sformatf("vec%0d grant", k), 32'(grant), 32'(vq[k].eg));
            chk($sformatf("vec%0d dwell_tick", k), 32'(dwell_tick), 32'(vq[k].et));
        end

        begin
            logic me;
            me = 1'b0;
            for (int c = 0; c < 600; c++) begin
                for (int i = 0; i < N; i++) if ($urandom_range(0, 3) == 0) s[i] = $urandom;
                if ($urandom_range(0, 24) == 0) me = ~me;
                cyc($urandom_range(0, 99) == 0,
                    ($urandom_range(0, 4) == 0) ? 4'b0000 : 4'($urandom),
                    $urandom_range(0, 7) == 0, me, 2'($urandom));
                chk("rand data32", data32, m_data);
                chk("rand cur_src", 32'(cur_src), 32'(m_src));
                chk("rand grant", 32'(grant), 32'(m_grant));
                chk("rand dwell_tick", 32'(dwell_tick), 32'(m_tick));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
